// File: rtl/locker_pkg.sv
// Shared definitions for the locker code-entry front end.
package locker_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SUBMIT  = 2'd1,
    ST_SHIFT   = 2'd2
  } entry_state_t;

  localparam int CODE_LEN_DEFAULT = 4;

endpackage

// File: rtl/locker_code_entry_if.sv
// Link from the code-entry block to the locker FSM and status consumers.
interface locker_code_entry_if #(
  parameter int CODE_LEN = locker_pkg::CODE_LEN_DEFAULT
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);

  logic             pwd_out;
  logic             submit_out;
  logic             busy;
  logic [CNT_W-1:0] entry_count;
  logic             short_err;

  modport master (
    output pwd_out, submit_out, busy, entry_count, short_err
  );

  modport slave (
    input pwd_out, submit_out, busy, entry_count, short_err
  );
endinterface

// File: rtl/locker_debounce.sv
// Two-flop synchronizer, consecutive-cycle debouncer and registered rising-edge press.
module locker_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_0;
  logic             sync_1;
  logic             clean;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // Last differing cycle of the run: the clean level flips on this edge.
  assign settle = (sync_1 != clean) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
      clean  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_0 <= raw;
      sync_1 <= sync_0;
      press  <= settle & sync_1;
      if (sync_1 == clean) begin
        cnt <= '0;
      end else if (settle) begin
        cnt   <= '0;
        clean <= sync_1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/locker_code_entry.sv
// Collects a CODE_LEN-bit code from two debounced keys and serializes it to the locker on enter.
module locker_code_entry
  import locker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CODE_LEN        = CODE_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key0_raw,
  input  logic                key1_raw,
  input  logic                enter_raw,
  locker_code_entry_if.master code_if
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);

  logic key0_p, key1_p, enter_p;

  locker_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_key0 (
    .clk(clk), .rst(rst), .raw(key0_raw), .press(key0_p)
  );
  locker_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_key1 (
    .clk(clk), .rst(rst), .raw(key1_raw), .press(key1_p)
  );
  locker_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(clk), .rst(rst), .raw(enter_raw), .press(enter_p)
  );

  entry_state_t  state, state_d;
  logic [CODE_LEN-1:0] code_buf, buf_d;
  logic [CNT_W-1:0]    count, count_d;
  logic [CNT_W-1:0]    idx, idx_d;
  logic short_d, pwd_d, submit_d, busy_d;
  logic pwd_q, submit_q, busy_q, short_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_COLLECT;
      code_buf <= '0;
      count    <= '0;
      idx      <= '0;
      pwd_q    <= 1'b0;
      submit_q <= 1'b0;
      busy_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state    <= state_d;
      code_buf <= buf_d;
      count    <= count_d;
      idx      <= idx_d;
      pwd_q    <= pwd_d;
      submit_q <= submit_d;
      busy_q   <= busy_d;
      short_q  <= short_d;
    end
  end

  always_comb begin
    state_d = state;
    buf_d   = code_buf;
    count_d = count;
    idx_d   = idx;
    short_d = 1'b0;
    case (state)
      ST_COLLECT: begin
        // Enter wins over a key press in the same cycle.
        if (enter_p) begin
          if (count == CNT_W'(CODE_LEN)) begin
            state_d = ST_SUBMIT;
          end else begin
            short_d = 1'b1;
            buf_d   = '0;
            count_d = '0;
          end
        end else if ((key0_p ^ key1_p) && (count < CNT_W'(CODE_LEN))) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (CNT_W'(i) == count) buf_d[i] = key1_p;
          end
          count_d = count + CNT_W'(1);
        end
      end
      ST_SUBMIT: begin
        state_d = ST_SHIFT;
        idx_d   = '0;
      end
      ST_SHIFT: begin
        if (idx == CNT_W'(CODE_LEN - 1)) begin
          state_d = ST_COLLECT;
          buf_d   = '0;
          count_d = '0;
          idx_d   = '0;
        end else begin
          idx_d = idx + CNT_W'(1);
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    submit_d = (state_d == ST_SUBMIT);
    busy_d   = (state_d != ST_COLLECT);
    pwd_d    = 1'b0;
    if (state_d == ST_SHIFT) begin
      for (int i = 0; i < CODE_LEN; i++) begin
        if (CNT_W'(i) == idx_d) pwd_d = code_buf[i];
      end
    end
  end

  assign code_if.pwd_out     = pwd_q;
  assign code_if.submit_out  = submit_q;
  assign code_if.busy        = busy_q;
  assign code_if.short_err   = short_q;
  assign code_if.entry_count = count;

endmodule

// File: tb/tb_locker_code_entry.sv
// Directed and random stimulus for locker_code_entry against a queue-based reference model.
module tb_locker_code_entry;
  import locker_pkg::*;

  localparam int LEN  = 4;
  localparam int HOLD = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key0_raw = 1'b0, key1_raw = 1'b0, enter_raw = 1'b0;

  locker_code_entry_if #(.CODE_LEN(LEN)) eif ();

  locker_code_entry #(.DEBOUNCE_CYCLES(16), .CODE_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .key0_raw(key0_raw), .key1_raw(key1_raw),
    .enter_raw(enter_raw), .code_if(eif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit   q[$];
  logic cap[$];
  int   cap_left = 0;
  int   n_submit = 0, n_short = 0, busy_cycles = 0, submit_pwd_err = 0, idle_pwd_err = 0;

  // Bus monitor: counts pulses and captures the bits that follow a submit.
  always @(negedge clk) begin
    if (rst) begin
      cap_left = 0;
    end else begin
      if (cap_left > 0) begin
        cap.push_back(eif.pwd_out);
        cap_left--;
      end
      if (eif.submit_out) begin
        n_submit++;
        cap_left = LEN;
        if (eif.pwd_out !== 1'b0) submit_pwd_err++;
      end
      if (eif.short_err) n_short++;
      if (eif.busy) busy_cycles++;
      if (!eif.busy && eif.pwd_out !== 1'b0) idle_pwd_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cap.delete();
    n_submit = 0; n_short = 0; busy_cycles = 0;
  endtask

  // which: 0 key0, 1 key1, 2 enter, 3 both keys, 4 enter with key0
  task automatic press(input int which);
    key0_raw  = (which == 0 || which == 3 || which == 4);
    key1_raw  = (which == 1 || which == 3);
    enter_raw = (which == 2 || which == 4);
    repeat (HOLD) @(negedge clk);
    key0_raw = 1'b0; key1_raw = 1'b0; enter_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic press_key(input bit b);
    press(b ? 1 : 0);
    if (q.size() < LEN) q.push_back(b);
    check("entry_count", 32'(eif.entry_count), q.size());
  endtask

  task automatic check_cap(input string tag);
    for (int i = 0; i < LEN; i++) begin
      check(tag, (i < cap.size()) ? 32'(cap[i]) : 32'd2, (i < q.size()) ? 32'(q[i]) : 32'd3);
    end
  endtask

  // Applies an enter press (optionally paired with key0) and checks the model's verdict.
  task automatic enter_and_check(input string tag, input int which);
    clear_mon();
    press(which);
    if (q.size() == LEN) begin
      check({tag, "_submit"}, n_submit, 1);
      check({tag, "_short"}, n_short, 0);
      check({tag, "_busy_len"}, busy_cycles, LEN + 1);
      check_cap({tag, "_bit"});
    end else begin
      check({tag, "_short"}, n_short, 1);
      check({tag, "_submit"}, n_submit, 0);
    end
    check({tag, "_count0"}, 32'(eif.entry_count), 0);
    q.delete();
  endtask

  initial begin
    bit secret[$] = '{1, 1, 0, 0};
    bit unlocked;
    bit seen;
    int cnt_before;

    repeat (3) @(negedge clk);
    check("rst_pwd", 32'(eif.pwd_out), 0);
    check("rst_submit", 32'(eif.submit_out), 0);
    check("rst_busy", 32'(eif.busy), 0);
    check("rst_count", 32'(eif.entry_count), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Bouncing key1 is rejected; a steady level is accepted once.
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) key1_raw = ~key1_raw;
      @(negedge clk);
    end
    check("bounce_count", 32'(eif.entry_count), 0);
    key1_raw = 1'b1;
    repeat (20) @(negedge clk);
    check("debounce_count", 32'(eif.entry_count), 1);
    key1_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
    q.push_back(1);
    enter_and_check("deb_enter", 2);

    // Correct code reaches the locker.
    press_key(1); press_key(1); press_key(0); press_key(0);
    enter_and_check("entry", 2);
    unlocked = (cap.size() == LEN);
    for (int i = 0; i < LEN; i++) if (unlocked && cap[i] !== logic'(secret[i])) unlocked = 0;
    check("unlocked", 32'(unlocked), 1);

    press_key(1); press_key(0);
    enter_and_check("short", 2);

    press_key(1); press_key(1); press_key(0); press_key(0); press_key(1); press_key(1);
    check("overflow_sat", 32'(eif.entry_count), 4);
    enter_and_check("overflow", 2);

    // Simultaneous keys are ignored; enter beats a coincident key.
    press_key(0);
    press(3);
    check("both_keys", 32'(eif.entry_count), q.size());
    press_key(1);
    enter_and_check("enter_key", 4);

    // Key press lands during SHIFT and must be dropped.
    press_key(1); press_key(0); press_key(1); press_key(0);
    clear_mon();
    enter_raw = 1'b1;
    repeat (3) @(negedge clk);
    key1_raw = 1'b1;
    repeat (HOLD - 3) @(negedge clk);
    enter_raw = 1'b0;
    repeat (3) @(negedge clk);
    key1_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("busy_submit", n_submit, 1);
    check_cap("busy_bit");
    check("busy_count0", 32'(eif.entry_count), 0);
    q.delete();

    // Random sequences against the model.
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          cnt_before = q.size();
          press(3);
          check("rnd_both", 32'(eif.entry_count), cnt_before);
        end
        press_key(1'($urandom_range(0, 1)));
      end
      enter_and_check("rnd", 2);
    end

    // Reset in the second SHIFT cycle aborts the transfer.
    press_key(1); press_key(1); press_key(1); press_key(1);
    clear_mon();
    enter_raw = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (eif.submit_out === 1'b1) seen = 1;
    end
    check("rst_test_submit_seen", 32'(seen), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_abort_pwd", 32'(eif.pwd_out), 0);
    check("rst_abort_busy", 32'(eif.busy), 0);
    check("rst_abort_count", 32'(eif.entry_count), 0);
    check("rst_abort_state", 32'(dut.state), 32'(ST_COLLECT));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    clear_mon();
    // Enter still held through reset release counts as a fresh press.
    repeat (HOLD) @(negedge clk);
    enter_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("held_enter_short", n_short, 1);
    check("post_rst_submit", n_submit, 0);
    check("post_rst_busy", busy_cycles, 0);
    check("post_rst_bits", cap.size(), 0);
    check("submit_pwd", submit_pwd_err, 0);
    check("idle_pwd", idle_pwd_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/locker_code_entry.md
LOCKER_CODE_ENTRY -- requirements
Module: locker_code_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the stable-level cycles required before a raw button change is accepted.
REQ-002 SHALL have parameter CODE_LEN, default 4, meaning the number of code bits per attempt.
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key0_raw  input  1  raw push-button, enters bit 0; asynchronous to clk and bouncing.
REQ-006 SHALL have port key1_raw  input  1  raw push-button, enters bit 1; asynchronous to clk and bouncing.
REQ-007 SHALL have port enter_raw  input  1  raw push-button, requests submission of the buffered code.
REQ-008 SHALL have port pwd_out  output  1  serial code bit to the locker FSM pwd_in.
REQ-009 SHALL have port submit_out  output  1  one-cycle pulse to the locker FSM submit.
REQ-010 SHALL have port busy  output  1  high while in SUBMIT or SHIFT.
REQ-011 SHALL have port entry_count  output  $clog2(CODE_LEN+1)  number of bits currently buffered.
REQ-012 SHALL have port short_err  output  1  one-cycle pulse when enter is pressed with an incomplete code.

Function
REQ-013 SHALL pass each raw input through a 2-flop synchronizer, then a debouncer that updates its clean level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the clean level restarts the count.
REQ-014 SHALL generate a one-cycle press event on each 0->1 transition of a clean level.
REQ-015 SHALL implement FSM states COLLECT, SUBMIT, SHIFT.
REQ-016 In COLLECT, a key0 or key1 press SHALL append 0 or 1 to the buffer and increment entry_count, provided entry_count < CODE_LEN; when the buffer is full, further key presses SHALL be ignored.
REQ-017 Simultaneous key0 and key1 press events in the same cycle SHALL both be ignored.
REQ-018 In COLLECT, an enter press with entry_count == CODE_LEN SHALL move the FSM to SUBMIT.
REQ-019 In COLLECT, an enter press with entry_count < CODE_LEN SHALL pulse short_err for one cycle, clear the buffer and entry_count to 0, and keep the FSM in COLLECT.
REQ-020 An enter press in the same cycle as a key press SHALL take priority; that key press SHALL be discarded.
REQ-021 SUBMIT SHALL last exactly one cycle with submit_out = 1 and pwd_out = 0, then go to SHIFT.
REQ-022 SHIFT SHALL last exactly CODE_LEN cycles, driving the buffered bits on pwd_out first-entered first, one bit per cycle.
REQ-023 On leaving SHIFT, the FSM SHALL return to COLLECT with the buffer and entry_count cleared.
REQ-024 Key and enter press events occurring during SUBMIT or SHIFT SHALL be ignored.
REQ-025 In COLLECT, pwd_out SHALL be 0 and submit_out SHALL be 0.
REQ-026 All outputs SHALL be registered.
REQ-027 Latency: submit_out SHALL rise in the cycle after the registered enter press event; the first code bit SHALL appear in the following cycle.

Reset
REQ-028 Asserting rst SHALL immediately force the FSM to COLLECT, the buffer and entry_count to 0, and pwd_out, submit_out, busy and short_err to 0.
REQ-029 Asserting rst SHALL force the synchronizers, debounce counters and clean levels to 0.
REQ-030 Reset asserted during SUBMIT or SHIFT SHALL abort the transfer with no further bits emitted.
REQ-031 A button held down through reset release SHALL register as a press once its debounce completes.

Structure
REQ-032 Shared package locker_pkg SHALL hold the entry FSM state enumeration and the default CODE_LEN constant.
REQ-033 Synchronizer, debounce and edge detection SHALL be one sub-module, locker_debounce, instantiated three times.

Verification
REQ-034 Debounce test: key1_raw toggled every 3 cycles for 40 cycles, then held high for 20 cycles -> exactly one press; entry_count 0->1.
REQ-035 Entry test: presses 1,1,0,0 then enter -> submit_out high for 1 cycle, then pwd_out = 1,1,0,0 on consecutive cycles; the downstream locker reaches unlocked = 1.
REQ-036 Short-entry test: presses 1,0 then enter -> short_err one-cycle pulse, entry_count = 0, submit_out never asserted.
REQ-037 Overflow test: presses 1,1,0,0,1,1 then enter -> only 1,1,0,0 serialized; entry_count saturates at 4.
REQ-038 Busy test: key presses during SHIFT -> ignored; entry_count = 0 after SHIFT ends.
REQ-039 Reset test: rst pulsed in the second SHIFT cycle -> pwd_out = 0 and busy = 0 immediately; state is COLLECT.
